video_timing_gen: RTL and testbench

//   Raster timing source for the display pipeline. Produces the pixel

---
 rtl/video_timing_gen.sv | 111 +++++++++++
 tb/tb_video_timing_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters with registered coordinate and sync outputs.
// Optional pixel clock-enable input pix_ce is added when VIDEO_TIMING_PIXEL_CE_EN is defined.
module video_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 48,
    parameter int H_SYNC   = 112,
    parameter int H_BP     = 248,
    parameter int V_ACTIVE = 1024,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 38,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
`ifdef VIDEO_TIMING_PIXEL_CE_EN
    input  logic        pix_ce,
`endif
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        valid,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 2048 || V_TOTAL > 2048 || V_ACTIVE > 1024) begin : g_bad_params
        $error("video_timing_gen: timing parameters exceed 11-bit counters or 10-bit y");
    end

    localparam logic [10:0] H_ACT_C  = 11'(H_ACTIVE);
    localparam logic [10:0] H_LAST_C = 11'(H_TOTAL - 1);
    localparam logic [10:0] HS_BEG_C = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END_C = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_C  = 11'(V_ACTIVE);
    localparam logic [10:0] V_LAST_C = 11'(V_TOTAL - 1);
    localparam logic [10:0] VS_BEG_C = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END_C = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic        ce;
`ifdef VIDEO_TIMING_PIXEL_CE_EN
    assign ce = pix_ce;
`else
    assign ce = 1'b1;
`endif

    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        valid_q, valid_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        fs_q, fs_d;
    logic        h_act, v_act;

    // Counter advance
    always_comb begin
        h_cnt_d = h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST_C) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST_C) ? '0 : v_cnt_q + 11'd1;
        end
    end

    // Output decode works on the pre-increment counters, giving one cycle of latency.
    always_comb begin
        h_act   = (h_cnt_q < H_ACT_C);
        v_act   = (v_cnt_q < V_ACT_C);
        valid_d = h_act & v_act;
        x_d     = h_act ? h_cnt_q : '0;
        y_d     = v_act ? v_cnt_q[9:0] : '0;
        hsync_d = ((h_cnt_q >= HS_BEG_C) && (h_cnt_q < HS_END_C)) ? SYNC_POL : ~SYNC_POL;
        vsync_d = ((v_cnt_q >= VS_BEG_C) && (v_cnt_q < VS_END_C)) ? SYNC_POL : ~SYNC_POL;
        fs_d    = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            fs_q    <= 1'b0;
        end else if (ce) begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            fs_q    <= fs_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign valid       = valid_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen using a small 14x7 raster (H 8/2/2/2, V 4/1/1/1).
module tb_video_timing_gen;

    localparam int HT = 14;
    localparam int VT = 7;
    localparam int FRAME = HT * VT;
    localparam int NVEC = 17;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pix_ce = 1'b1;
    logic [10:0] x;
    logic [9:0]  y;
    logic        valid, hsync, vsync, frame_start;

    int errors = 0;
    int checks = 0;

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
`ifdef VIDEO_TIMING_PIXEL_CE_EN
        .pix_ce(pix_ce),
`endif
        .x(x),
        .y(y),
        .valid(valid),
        .hsync(hsync),
        .vsync(vsync),
        .frame_start(frame_start)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        int          edge_n;
        logic [10:0] x;
        logic [9:0]  y;
        logic        valid;
        logic        hs;
        logic        vs;
        logic        fs;
    } vec_t;

    vec_t tbl[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_out();
        return {8'd0, x, y, valid, hsync, vsync, frame_start};
    endfunction

    function automatic logic [31:0] pack_vec(input vec_t v);
        return {8'd0, v.x, v.y, v.valid, v.hs, v.vs, v.fs};
    endfunction

    task automatic sample_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ti;
        int valid_cnt[3];
        int vs_cnt[3];
        int hs_cnt[3];
        int fs_edges[$];
        bit found;

        //           edge  x       y      v     hs    vs    fs
        tbl[0]  = '{1,   11'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{2,   11'd1, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{8,   11'd7, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{9,   11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{11,  11'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{12,  11'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{13,  11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{15,  11'd0, 10'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{34,  11'd5, 10'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{50,  11'd7, 10'd3, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{57,  11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{71,  11'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{81,  11'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{85,  11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{98,  11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{99,  11'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{100, 11'd1, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0};

        // reset held 5 cycles, outputs at reset value throughout
        for (int i = 0; i < 5; i++) begin
            sample_edge();
            check("reset_hold", pack_out(), 32'd0);
        end
        @(negedge clk) reset = 1'b1;

        // table vectors plus per-frame statistics over 3 frames
        ti = 0;
        for (int f = 0; f < 3; f++) begin
            valid_cnt[f] = 0;
            vs_cnt[f] = 0;
            hs_cnt[f] = 0;
        end
        for (int e = 1; e <= 3 * FRAME; e++) begin
            int f;
            sample_edge();
            f = (e - 1) / FRAME;
            if (ti < NVEC && tbl[ti].edge_n == e) begin
                check($sformatf("vec_edge%0d", e), pack_out(), pack_vec(tbl[ti]));
                ti++;
            end
            if (valid) begin
                valid_cnt[f]++;
                if (y > 10'd3 || x > 11'd7) check("active_range", {11'd0, y, x}, 32'd0);
            end
            if (vsync) vs_cnt[f]++;
            if (hsync) hs_cnt[f]++;
            if (frame_start) fs_edges.push_back(e);
        end
        check("table_done", ti, NVEC);
        for (int f = 0; f < 3; f++) begin
            check($sformatf("valid_count_f%0d", f), valid_cnt[f], 32);
            check($sformatf("vsync_count_f%0d", f), vs_cnt[f], HT);
            check($sformatf("hsync_count_f%0d", f), hs_cnt[f], 2 * VT);
        end
        check("fs_count", fs_edges.size(), 3);
        if (fs_edges.size() == 3) begin
            check("fs_first", fs_edges[0], 1);
            check("fs_period_0", fs_edges[1] - fs_edges[0], FRAME);
            check("fs_period_1", fs_edges[2] - fs_edges[1], FRAME);
        end

        // mid-line asynchronous reset at (5,2)
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            sample_edge();
            if (x == 11'd5 && y == 10'd2) found = 1'b1;
        end
        check("find_x5y2", found, 1'b1);
        #2 reset = 1'b0;
        #1 check("async_reset", pack_out(), 32'd0);
        for (int i = 0; i < 3; i++) begin
            sample_edge();
            check("reset_mid_hold", pack_out(), 32'd0);
        end
        @(negedge clk) reset = 1'b1;
        sample_edge();
        check("restart_e1", pack_out(), {8'd0, 11'd0, 10'd0, 4'b1001});
        sample_edge();
        check("restart_e2", pack_out(), {8'd0, 11'd1, 10'd0, 4'b1000});
        for (int e = 3; e <= 10; e++) begin
            sample_edge();
            check("restart_no_sync", {hsync, vsync}, 2'b00);
        end
        sample_edge();
        check("restart_hsync_e11", {hsync, vsync}, 2'b10);

`ifdef VIDEO_TIMING_PIXEL_CE_EN
        // clock enable every 3rd cycle: each state held 3 cycles
        @(negedge clk) reset = 1'b0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 3 * FRAME + 6; c++) begin
            int k, h, v;
            logic [10:0] ex;
            logic        efs;
            pix_ce = (c % 3 == 0);
            if (c == 0) reset = 1'b1;
            sample_edge();
            k   = c / 3;
            h   = k % HT;
            v   = (k / HT) % VT;
            ex  = (h < 8) ? 11'(h) : 11'd0;
            efs = (h == 0 && v == 0);
            check($sformatf("ce_x_c%0d", c), x, ex);
            check($sformatf("ce_fs_c%0d", c), frame_start, efs);
            @(negedge clk);
        end
        pix_ce = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
